// File: rtl/riscv_dm_pkg.sv
// Shared Debug Module definitions: DMI field widths, response codes and the
// state type of the DMI transport arbiter.
package riscv_dm_pkg;

    localparam int DMI_ADDR_WIDTH = 7;
    localparam int DMI_DATA_WIDTH = 32;
    localparam int DMI_OP_WIDTH   = 2;

    localparam logic [DMI_OP_WIDTH-1:0] RD_OP_SUCCESS = 2'd0;
    localparam logic [DMI_OP_WIDTH-1:0] RD_OP_FAILED  = 2'd2;
    localparam logic [DMI_OP_WIDTH-1:0] RD_OP_BUSY    = 2'd3;

    localparam int DMI_ARB_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_RESP,
        ARB_DRAIN
    } arb_state_t;

endpackage

// File: rtl/riscv_rr_picker.sv
// Combinational round-robin select: first asserted request at or above i_ptr,
// wrapping around. Reusable by any debug-side arbiter.
module riscv_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int w_pos;

    // Walk offsets from the far end so the lowest offset from i_ptr wins last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/riscv_dmi_arbiter.sv
// Shares the Debug Module DMI port between NUM_REQ transports, one transaction
// at a time, with a response watchdog. States: IDLE/REQ/WAIT/RESP/DRAIN.
module riscv_dmi_arbiter
    import riscv_dm_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = DMI_ARB_TIMEOUT_DEFAULT
) (
    input  logic                               clk_i,
    input  logic                               trst_i,
    input  logic [NUM_REQ-1:0]                 up_req_valid_i,
    output logic [NUM_REQ-1:0]                 up_req_ready_o,
    input  logic [NUM_REQ*DMI_ADDR_WIDTH-1:0]  up_req_addr_i,
    input  logic [NUM_REQ*DMI_DATA_WIDTH-1:0]  up_req_data_i,
    input  logic [NUM_REQ*DMI_OP_WIDTH-1:0]    up_req_op_i,
    output logic [NUM_REQ-1:0]                 up_resp_valid_o,
    input  logic [NUM_REQ-1:0]                 up_resp_ready_i,
    output logic [DMI_DATA_WIDTH-1:0]          up_resp_data_o,
    output logic [DMI_OP_WIDTH-1:0]            up_resp_op_o,
    output logic                               dm_req_valid_o,
    input  logic                               dm_req_ready_i,
    output logic [DMI_ADDR_WIDTH-1:0]          dm_req_addr_o,
    output logic [DMI_DATA_WIDTH-1:0]          dm_req_data_o,
    output logic [DMI_OP_WIDTH-1:0]            dm_req_op_o,
    input  logic                               dm_resp_valid_i,
    output logic                               dm_resp_ready_o,
    input  logic [DMI_DATA_WIDTH-1:0]          dm_resp_data_i,
    input  logic [DMI_OP_WIDTH-1:0]            dm_resp_op_i,
    output logic                               busy_o
);

    localparam int AW    = DMI_ADDR_WIDTH;
    localparam int DW    = DMI_DATA_WIDTH;
    localparam int OW    = DMI_OP_WIDTH;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr, r_grant, w_pick_idx, w_grant_inc;
    logic             w_pick_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timed_out, r_run;
    logic [AW-1:0]    r_req_addr;
    logic [DW-1:0]    r_req_data, r_resp_data;
    logic [OW-1:0]    r_req_op, r_resp_op;
    logic             w_accept, w_dm_req_hs, w_dm_resp_hs, w_expire;
    logic             w_up_resp_hs, w_drain_done;

    riscv_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .i_req   (up_req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_grant_inc = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + IDX_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        up_req_ready_o  = '0;
        up_resp_valid_o = '0;
        dm_req_valid_o  = 1'b0;
        dm_resp_ready_o = 1'b0;
        w_accept        = 1'b0;
        w_dm_req_hs     = 1'b0;
        w_dm_resp_hs    = 1'b0;
        w_expire        = 1'b0;
        w_up_resp_hs    = 1'b0;
        w_drain_done    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid && r_run) begin
                    up_req_ready_o[w_pick_idx] = 1'b1;
                    w_accept    = 1'b1;
                    w_state_nxt = ARB_REQ;
                end
            end
            ARB_REQ: begin
                dm_req_valid_o = 1'b1;
                if (dm_req_ready_i) begin
                    w_dm_req_hs = 1'b1;
                    w_state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                dm_resp_ready_o = 1'b1;
                if (dm_resp_valid_i) begin
                    w_dm_resp_hs = 1'b1;
                    w_state_nxt  = ARB_RESP;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == CNT_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ARB_RESP;
                end
            end
            ARB_RESP: begin
                up_resp_valid_o[r_grant] = 1'b1;
                if (up_resp_ready_i[r_grant]) begin
                    w_up_resp_hs = 1'b1;
                    w_state_nxt  = r_timed_out ? ARB_DRAIN : ARB_IDLE;
                end
            end
            ARB_DRAIN: begin
                dm_resp_ready_o = 1'b1;
                if (dm_resp_valid_i) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // r_run holds off grants until the first clock after reset release.
    always_ff @(posedge clk_i or posedge trst_i) begin
        if (trst_i) begin
            r_state     <= ARB_IDLE;
            r_run       <= 1'b0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_timed_out <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_op    <= '0;
            r_resp_data <= '0;
            r_resp_op   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (w_accept) begin
                r_grant    <= w_pick_idx;
                r_req_addr <= up_req_addr_i[int'(w_pick_idx)*AW +: AW];
                r_req_data <= up_req_data_i[int'(w_pick_idx)*DW +: DW];
                r_req_op   <= up_req_op_i[int'(w_pick_idx)*OW +: OW];
            end
            if (w_dm_req_hs) begin
                r_cnt <= '0;
            end else if (r_state == ARB_WAIT && !w_dm_resp_hs && !w_expire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_dm_resp_hs) begin
                r_resp_data <= dm_resp_data_i;
                r_resp_op   <= dm_resp_op_i;
            end else if (w_expire) begin
                r_resp_data <= '0;
                r_resp_op   <= RD_OP_FAILED;
                r_timed_out <= 1'b1;
            end
            if (w_up_resp_hs) begin
                r_rr_ptr <= w_grant_inc;
            end
            if (w_drain_done) begin
                r_timed_out <= 1'b0;
            end
        end
    end

    assign dm_req_addr_o  = r_req_addr;
    assign dm_req_data_o  = r_req_data;
    assign dm_req_op_o    = r_req_op;
    assign up_resp_data_o = r_resp_data;
    assign up_resp_op_o   = r_resp_op;
    assign busy_o         = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
// Randomised bench for riscv_dmi_arbiter: transaction-level round-robin model
// plus a scoreboard of expected upstream responses.
module tb_riscv_dmi_arbiter;
    import riscv_dm_pkg::*;

    localparam int N  = 2;
    localparam int TO = 8;
    localparam int AW = DMI_ADDR_WIDTH;
    localparam int DW = DMI_DATA_WIDTH;
    localparam int OW = DMI_OP_WIDTH;

    typedef struct {
        int            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [OW-1:0] op;
        logic [DW-1:0] rdata;
        logic [OW-1:0] rop;
        bit            timed_out;
    } txn_t;

    logic            clk_i = 1'b0;
    logic            trst_i;
    logic [N-1:0]    up_req_valid_i;
    logic [N-1:0]    up_req_ready_o;
    logic [N*AW-1:0] up_req_addr_i;
    logic [N*DW-1:0] up_req_data_i;
    logic [N*OW-1:0] up_req_op_i;
    logic [N-1:0]    up_resp_valid_o;
    logic [N-1:0]    up_resp_ready_i;
    logic [DW-1:0]   up_resp_data_o;
    logic [OW-1:0]   up_resp_op_o;
    logic            dm_req_valid_o;
    logic            dm_req_ready_i;
    logic [AW-1:0]   dm_req_addr_o;
    logic [DW-1:0]   dm_req_data_o;
    logic [OW-1:0]   dm_req_op_o;
    logic            dm_resp_valid_i;
    logic            dm_resp_ready_o;
    logic [DW-1:0]   dm_resp_data_i;
    logic [OW-1:0]   dm_resp_op_i;
    logic            busy_o;

    int   total = 0;
    int   bad   = 0;
    txn_t dm_exp[$];
    txn_t pend[$];
    txn_t sb[$];
    bit   m_free, m_drain, m_req_phase;
    int   m_ptr;
    bit   resp_armed;
    int   resp_cnt;

    riscv_dmi_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk_i),
        .trst_i          (trst_i),
        .up_req_valid_i  (up_req_valid_i),
        .up_req_ready_o  (up_req_ready_o),
        .up_req_addr_i   (up_req_addr_i),
        .up_req_data_i   (up_req_data_i),
        .up_req_op_i     (up_req_op_i),
        .up_resp_valid_o (up_resp_valid_o),
        .up_resp_ready_i (up_resp_ready_i),
        .up_resp_data_o  (up_resp_data_o),
        .up_resp_op_o    (up_resp_op_o),
        .dm_req_valid_o  (dm_req_valid_o),
        .dm_req_ready_i  (dm_req_ready_i),
        .dm_req_addr_o   (dm_req_addr_o),
        .dm_req_data_o   (dm_req_data_o),
        .dm_req_op_o     (dm_req_op_o),
        .dm_resp_valid_i (dm_resp_valid_i),
        .dm_resp_ready_o (dm_resp_ready_o),
        .dm_resp_data_i  (dm_resp_data_i),
        .dm_resp_op_i    (dm_resp_op_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] dm_reply(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return d ^ {a, {(DW-AW){1'b0}}} ^ 32'h5A5A_0F0F;
    endfunction

    // Transaction-level model and checker: one outstanding transaction, round-robin order.
    always @(negedge clk_i) begin
        logic [N-1:0] exp_rdy;
        int           win;
        txn_t         t;
        if (trst_i) begin
            m_free      = 1'b1;
            m_drain     = 1'b0;
            m_req_phase = 1'b0;
            m_ptr       = 0;
            dm_exp.delete();
            pend.delete();
            sb.delete();
        end else begin
            exp_rdy = '0;
            win     = -1;
            if (m_free) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (up_req_valid_i[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            chk("busy", 64'(busy_o), 64'(!m_free));
            chk("req_ready", 64'(up_req_ready_o), 64'(exp_rdy));
            chk("dm_req_valid", 64'(dm_req_valid_o), 64'(m_req_phase));
            if (m_req_phase && dm_exp.size() > 0) begin
                t = dm_exp[0];
                chk("dm_req_payload", 64'({dm_req_addr_o, dm_req_op_o, dm_req_data_o}),
                    64'({t.addr, t.op, t.data}));
                if (dm_req_ready_i) begin
                    pend.push_back(dm_exp.pop_front());
                    m_req_phase = 1'b0;
                end
            end
            if (up_resp_valid_o != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 64'(up_resp_valid_o), 64'd0);
                end else begin
                    t = sb[0];
                    chk("resp_valid", 64'(up_resp_valid_o), 64'(1) << t.id);
                    chk("resp_payload", 64'({up_resp_op_o, up_resp_data_o}), 64'({t.rop, t.rdata}));
                    chk("resp_dm_ready_low", 64'(dm_resp_ready_o), 64'd0);
                    if (up_resp_ready_i[t.id]) begin
                        void'(sb.pop_front());
                        m_ptr = (t.id + 1) % N;
                        if (t.timed_out) m_drain = 1'b1;
                        else             m_free  = 1'b1;
                    end
                end
            end else if (m_drain && dm_resp_valid_i && dm_resp_ready_o) begin
                m_drain = 1'b0;
                m_free  = 1'b1;
            end
            if (win >= 0) begin
                t.id        = win;
                t.addr      = up_req_addr_i[win*AW +: AW];
                t.data      = up_req_data_i[win*DW +: DW];
                t.op        = up_req_op_i[win*OW +: OW];
                t.rdata     = '0;
                t.rop       = '0;
                t.timed_out = 1'b0;
                dm_exp.push_back(t);
                m_free      = 1'b0;
                m_req_phase = 1'b1;
            end
        end
    end

    // Drive requesters, DM and upstream response acceptance for n cycles.
    task automatic run_cycles(input int n, input logic [N-1:0] mask, input int p_req,
                              input int p_dmrdy, input int dmin, input int dmax, input int p_uprdy);
        logic [N-1:0] hs_up;
        logic         hs_dmreq, hs_dmresp;
        txn_t         t;
        int           d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            hs_up     = up_req_valid_i & up_req_ready_o;
            hs_dmreq  = dm_req_valid_o & dm_req_ready_i;
            hs_dmresp = dm_resp_valid_i & dm_resp_ready_o;
            @(posedge clk_i);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs_up[i]) up_req_valid_i[i] = 1'b0;
                if (!up_req_valid_i[i] && mask[i] && $urandom_range(99) < p_req) begin
                    up_req_valid_i[i]          = 1'b1;
                    up_req_addr_i[i*AW +: AW]  = AW'($urandom);
                    up_req_data_i[i*DW +: DW]  = $urandom;
                    up_req_op_i[i*OW +: OW]    = OW'($urandom_range(2));
                end
                up_resp_ready_i[i] = ($urandom_range(99) < p_uprdy);
            end
            dm_req_ready_i = ($urandom_range(99) < p_dmrdy);
            if (hs_dmresp) dm_resp_valid_i = 1'b0;
            if (resp_armed) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dm_resp_valid_i = 1'b1;
                    resp_armed      = 1'b0;
                end
            end
            if (hs_dmreq && pend.size() > 0) begin
                t              = pend.pop_front();
                d              = $urandom_range(dmax, dmin);
                dm_resp_data_i = dm_reply(t.addr, t.data);
                dm_resp_op_i   = ($urandom_range(1) == 1) ? RD_OP_BUSY : RD_OP_SUCCESS;
                t.timed_out    = (d >= TO);
                t.rdata        = t.timed_out ? '0 : dm_resp_data_i;
                t.rop          = t.timed_out ? RD_OP_FAILED : dm_resp_op_i;
                sb.push_back(t);
                if (d == 0) begin
                    dm_resp_valid_i = 1'b1;
                end else begin
                    resp_cnt   = d;
                    resp_armed = 1'b1;
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({up_req_ready_o, up_resp_valid_o, dm_req_valid_o, dm_resp_ready_o, busy_o}), 64'd0);
        chk({tag, "_dm_req"}, 64'({dm_req_addr_o, dm_req_op_o, dm_req_data_o}), 64'd0);
        chk({tag, "_resp"}, 64'({up_resp_op_o, up_resp_data_o}), 64'd0);
    endtask

    initial begin
        trst_i          = 1'b1;
        up_req_valid_i  = '0;
        up_req_addr_i   = '0;
        up_req_data_i   = '0;
        up_req_op_i     = '0;
        up_resp_ready_i = '0;
        dm_req_ready_i  = 1'b0;
        dm_resp_valid_i = 1'b0;
        dm_resp_data_i  = '0;
        dm_resp_op_i    = '0;
        resp_armed      = 1'b0;
        resp_cnt        = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        #1 trst_i = 1'b0;

        run_cycles(12,  2'b01, 100, 100, 3, 3, 100);
        run_cycles(800, 2'b11, 60,  60,  0, 11, 60);
        run_cycles(300, 2'b11, 100, 100, 0, 3, 100);
        run_cycles(300, 2'b11, 100, 30,  0, 12, 30);
        run_cycles(60,  2'b00, 0,   100, 0, 2, 100);

        // Leave the pointer at 1, then reset while requester 1 waits on the DM.
        run_cycles(12,  2'b01, 100, 100, 0, 1, 100);
        run_cycles(30,  2'b00, 0,   100, 0, 1, 100);
        run_cycles(3,   2'b10, 100, 100, 20, 20, 100);
        chk("pre_reset_wait", 64'({busy_o, dm_resp_ready_o}), 64'd3);
        #2 trst_i = 1'b1;
        #1;
        chk_all_zero("async_reset");
        up_req_valid_i  = '0;
        dm_resp_valid_i = 1'b0;
        resp_armed      = 1'b0;
        @(negedge clk_i);
        #1 trst_i = 1'b0;

        run_cycles(40,  2'b11, 100, 100, 0, 2, 100);
        run_cycles(60,  2'b00, 0,   100, 0, 2, 100);
        chk("final_queues_empty", 64'(sb.size() + dm_exp.size() + pend.size()), 64'd0);
        chk("final_idle", 64'(busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
